dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data RAM between the core's data port (m0) and a secondary master (m1: loader/DMA). The RAM has a combinational read and a write committed on the clock edge. The block selects one owner per cycle using round-robin, and supports a bounded lock for bursts. It drives the RAM address, write enable and write data, and returns registered read data with a valid strobe. It sits between the masters and the RAM's DMemCtrl input (addr, en, in) and data_out.

## Interface
- D, 8, data width
- A, 8, address width
- LOCK_MAX, 16, maximum consecutive locked cycles before forced release (≥2)
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- mX_req  in  1  request, X∈{0,1}
- mX_we  in  1  1=write, 0=read
- mX_addr  in  A  address
- mX_wdata  in  D  write data
- mX_lock  in  1  request to keep ownership on following cycles
- mX_gnt  out  1  transfer accepted this cycle (combinational)
- mX_rvalid  out  1  read data valid (registered)
- mX_rdata  out  D  read data (registered)
- ram_addr  out  A  to DMemCtrl.addr
- ram_en  out  1  to DMemCtrl.en (write enable)
- ram_in  out  D  to DMemCtrl.in
- ram_data  in  D  from RAM data_out

## Operation
- State: owner FSM {FREE, LOCK0, LOCK1}; last (1 bit, last granted master); lock_cnt (clog2(LOCK_MAX) bits).
- Grant selection in FREE: if only one master requests, that master wins. If both request, the master ≠ last wins.
- Grant selection in LOCKx: mX wins if mX_req; otherwise no grant (cycle idle). The other master is stalled.
- At most one gnt is high per cycle. The gnt for a master is never high without its req.
- RAM mux: ram_addr/ram_in come from the granted master; ram_en = gnt & we of that master. With no grant, ram_en=0, and ram_addr/ram_in hold m0's values (don't-care, but must be stable).
- A granted read latches ram_data into mX_rdata at the posedge. mX_rvalid=1 for exactly the next cycle. mX_rdata holds its value until the next read by that master.
- last ← granted master on every granted cycle.
- FSM transitions, evaluated at posedge:
  - FREE→LOCKx: mX granted with mX_lock=1; lock_cnt←1.
  - LOCKx→LOCKx: mX_lock=1 and lock_cnt<LOCK_MAX−1; lock_cnt increments every cycle, with or without a grant.
  - LOCKx→FREE: mX_lock=0. Any transfer with lock=0 in that cycle is still granted.
  - LOCKx→FREE (forced): lock_cnt=LOCK_MAX−1, regardless of lock. last←x so the other master wins the next tie.
- Simultaneous events:
  - Forced release and new lock request in the same cycle: release wins; LOCKx is re-entered only through a later FREE grant.
  - Read and write to the same address from different masters: serialized; the order follows the grant order.

## Timing
- Reset values: FSM=FREE, last=1 (m0 wins the first tie), lock_cnt=0, mX_rvalid=0, mX_rdata=0.
- While rst_n=0: all gnt=0 and ram_en=0 (forced combinationally).
- Write: gnt in cycle t; RAM updated at the posedge ending t. A read of the same address in t+1 returns the new data.
- Read: gnt in cycle t; mX_rvalid and mX_rdata valid in t+1. Back-to-back reads give rvalid every cycle.
- Throughput: one transfer per cycle total. Under continuous contention without lock, the masters alternate 1:1.
- Reset asserted mid-lock: FSM returns to FREE immediately; pending rvalid is cleared.
- lock_cnt never wraps; it saturates into forced release.

## Test plan
- Reset then m0 and m1 both request reads of 0x10/0x20 continuously → grants m0,m1,m0,m1…; each rvalid arrives 1 cycle after its gnt, carrying the RAM contents.
- m1 alone writes 0xA5 to 0x33, then m0 reads 0x33 next cycle → m0_rdata=0xA5, m0_rvalid on the cycle after m0_gnt.
- m0 locks with LOCK_MAX=16, issuing 4 writes while m1 requests throughout → m1_gnt=0 for those 4 cycles; m0 drops lock on its 4th write; m1 granted the following cycle.
- m0 holds lock forever with m1 requesting → m1 granted on cycle 17 after lock entry (forced release); afterwards m1 wins the tie.
- rst_n pulsed low mid-lock during a read → rvalid, rdata=0, gnt=0 and ram_en=0 while low; FREE after release; first tie goes to m0.
- No requests for 10 cycles → ram_en=0, both gnt=0, both rvalid=0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Per-master data-memory port: request/lock bundle in,
// grant and registered read return out.
interface dmem_arbiter_if #(
  parameter int A = 8,
  parameter int D = 8
);
  logic         req;
  logic         we;
  logic         lock;
  logic [A-1:0] addr;
  logic [D-1:0] wdata;
  logic         gnt;
  logic         rvalid;
  logic [D-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data RAM between two
// masters, with bounded burst lock and registered read data.
module dmem_arbiter #(
  parameter int D        = 8,
  parameter int A        = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  dmem_arbiter_if.slave       m0,
  dmem_arbiter_if.slave       m1,
  output logic [A-1:0]        ram_addr,
  output logic                ram_en,
  output logic [D-1:0]        ram_in,
  input  logic [D-1:0]        ram_data
);

  localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] CMAX = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid1_q;
  logic [D-1:0]  rdata0_q, rdata1_q;
  logic          g0, g1;
  logic          own_lock;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state_q)
      LOCK0: g0 = m0.req;
      LOCK1: g1 = m1.req;
      default: begin
        // on a tie the master that did not go last wins
        g0 = m0.req & (~m1.req | last_q);
        g1 = m1.req & (~m0.req | ~last_q);
      end
    endcase
    if (!rst_n) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end
  end

  assign own_lock = (state_q == LOCK1) ? m1.lock
                                       : m0.lock;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (g0) begin
      last_d = 1'b0;
    end else if (g1) begin
      last_d = 1'b1;
    end
    unique case (state_q)
      LOCK0, LOCK1: begin
        if (cnt_q == CMAX) begin
          state_d = FREE;
          cnt_d   = '0;
          last_d  = (state_q == LOCK1);
        end else if (!own_lock) begin
          state_d = FREE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (g0 && m0.lock) begin
          state_d = LOCK0;
          cnt_d   = CW'(1);
        end else if (g1 && m1.lock) begin
          state_d = LOCK1;
          cnt_d   = CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FREE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= g0 & ~m0.we;
      rvalid1_q <= g1 & ~m1.we;
      if (g0 && !m0.we) begin
        rdata0_q <= ram_data;
      end
      if (g1 && !m1.we) begin
        rdata1_q <= ram_data;
      end
    end
  end

  assign ram_addr  = g1 ? m1.addr : m0.addr;
  assign ram_in    = g1 ? m1.wdata : m0.wdata;
  assign ram_en    = (g0 & m0.we) | (g1 & m1.we);

  assign m0.gnt    = g0;
  assign m1.gnt    = g1;
  assign m0.rvalid = rvalid0_q;
  assign m1.rvalid = rvalid1_q;
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random
// traffic against a cycle-level behavioural model.
module tb_dmem_arbiter;
  localparam int D  = 8;
  localparam int A  = 8;
  localparam int LM = 16;

  typedef struct packed {
    logic         req;
    logic         we;
    logic         lock;
    logic [A-1:0] addr;
    logic [D-1:0] wdata;
  } rq_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [A-1:0] ram_addr;
  logic         ram_en;
  logic [D-1:0] ram_in;
  logic [D-1:0] ram_data;
  logic [D-1:0] mem [256];

  dmem_arbiter_if #(.A(A), .D(D)) p0 ();
  dmem_arbiter_if #(.A(A), .D(D)) p1 ();

  dmem_arbiter #(.D(D), .A(A), .LOCK_MAX(LM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m0       (p0),
    .m1       (p1),
    .ram_addr (ram_addr),
    .ram_en   (ram_en),
    .ram_in   (ram_in),
    .ram_data (ram_data)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] ival(input int i);
    return D'(i * 37 + 5);
  endfunction

  // RAM model: combinational read, clocked write, preset in reset
  assign ram_data = mem[ram_addr];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= ival(i);
    end else if (ram_en) begin
      mem[ram_addr] <= ram_in;
    end
  end

  int           nvec;
  int           nmis;
  int           m_owner;
  int           m_owned;
  logic         m_last;
  logic         m_rv [2];
  logic [D-1:0] m_rd [2];
  logic [D-1:0] gold [256];
  logic         s_g0, s_g1;

  function automatic rq_t mk(input logic r, input logic w,
                             input logic l, input int a,
                             input int d);
    return {r, w, l, A'(a), D'(d)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input rq_t x0, input rq_t x1);
    p0.req = x0.req; p0.we = x0.we; p0.lock = x0.lock;
    p0.addr = x0.addr; p0.wdata = x0.wdata;
    p1.req = x1.req; p1.we = x1.we; p1.lock = x1.lock;
    p1.addr = x1.addr; p1.wdata = x1.wdata;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_owned = 0;
    m_last  = 1'b1;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    m_rd[0] = '0;   m_rd[1] = '0;
    for (int i = 0; i < 256; i++) gold[i] = ival(i);
  endtask

  task automatic rst_step(input rq_t x0, input rq_t x1);
    @(negedge clk);
    rst_n = 1'b0;
    drive(x0, x1);
    #1;
    chk("rst_m0_gnt", p0.gnt, 0);
    chk("rst_m1_gnt", p1.gnt, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_m0_rvalid", p0.rvalid, 0);
    chk("rst_m1_rvalid", p1.rvalid, 0);
    chk("rst_m0_rdata", p0.rdata, 0);
    chk("rst_m1_rdata", p1.rdata, 0);
    model_reset();
  endtask

  task automatic step(input rq_t x0, input rq_t x1);
    rq_t  x [2];
    int   win;
    logic exp_en;
    x[0] = x0;
    x[1] = x1;
    @(negedge clk);
    rst_n = 1'b1;
    drive(x0, x1);
    #1;
    if (m_owner < 0) begin
      if (x0.req && x1.req) win = m_last ? 0 : 1;
      else if (x0.req)      win = 0;
      else if (x1.req)      win = 1;
      else                  win = -1;
    end else begin
      win = x[m_owner].req ? m_owner : -1;
    end
    exp_en = 1'b0;
    if (win >= 0) exp_en = x[win].we;
    s_g0 = p0.gnt;
    s_g1 = p1.gnt;
    chk("m0_gnt", p0.gnt, win == 0);
    chk("m1_gnt", p1.gnt, win == 1);
    chk("ram_en", ram_en, exp_en);
    chk("ram_addr", ram_addr, (win == 1) ? x1.addr : x0.addr);
    if (exp_en) chk("ram_in", ram_in, x[win].wdata);
    chk("m0_rvalid", p0.rvalid, m_rv[0]);
    chk("m1_rvalid", p1.rvalid, m_rv[1]);
    chk("m0_rdata", p0.rdata, m_rd[0]);
    chk("m1_rdata", p1.rdata, m_rd[1]);
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (win >= 0) begin
      m_last = win[0];
      if (x[win].we) begin
        gold[x[win].addr] = x[win].wdata;
      end else begin
        m_rv[win] = 1'b1;
        m_rd[win] = gold[x[win].addr];
      end
    end
    // ownership lasts at most LM cycles counting the entry cycle
    if (m_owner < 0) begin
      if (win >= 0 && x[win].lock) begin
        m_owner = win;
        m_owned = 1;
      end
    end else begin
      m_owned++;
      if (m_owned >= LM) begin
        m_last  = m_owner[0];
        m_owner = -1;
      end else if (!x[m_owner].lock) begin
        m_owner = -1;
      end
    end
  endtask

  rq_t idle;
  int  first;

  initial begin
    nvec = 0;
    nmis = 0;
    idle = mk(0, 0, 0, 0, 0);
    drive(idle, idle);
    model_reset();

    rst_step(idle, idle);
    rst_step(idle, idle);

    for (int i = 0; i < 6; i++) begin
      step(mk(1, 0, 0, 8'h10, 0), mk(1, 0, 0, 8'h20, 0));
      chk("alt_m0", s_g0, (i % 2) == 0);
      chk("alt_m1", s_g1, (i % 2) == 1);
    end

    step(idle, mk(1, 1, 0, 8'h33, 8'hA5));
    step(mk(1, 0, 0, 8'h33, 0), idle);
    step(idle, idle);
    chk("raw_rvalid", p0.rvalid, 1);
    chk("raw_rdata", p0.rdata, 8'hA5);

    step(idle, mk(1, 0, 0, 8'h05, 0));
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 1, k < 3, 8'h40 + k, k + 1),
           mk(1, 0, 0, 8'h20, 0));
      chk("lk_m0_gnt", s_g0, 1);
      chk("lk_m1_stall", s_g1, 0);
    end
    step(idle, mk(1, 0, 0, 8'h20, 0));
    chk("lk_m1_after", s_g1, 1);

    first = -1;
    for (int c = 1; c <= 40 && first < 0; c++) begin
      step(mk(1, 1, 1, 8'h50, c), mk(1, 0, 0, 8'h21, 0));
      if (s_g1) first = c;
    end
    chk("forced_rel_cycle", first, 17);

    for (int k = 0; k < 3; k++)
      step(mk(1, 0, 1, 8'h50, 0), mk(1, 0, 0, 8'h21, 0));
    rst_step(mk(1, 0, 1, 8'h50, 0), mk(1, 0, 0, 8'h21, 0));
    rst_step(mk(1, 0, 1, 8'h50, 0), mk(1, 0, 0, 8'h21, 0));
    step(mk(1, 0, 0, 8'h11, 0), mk(1, 0, 0, 8'h22, 0));
    chk("post_rst_tie", s_g0, 1);

    for (int k = 0; k < 10; k++) begin
      step(idle, idle);
      chk("idle_en", ram_en, 0);
    end
    chk("idle_rv0", p0.rvalid, 0);
    chk("idle_rv1", p1.rvalid, 0);

    for (int k = 0; k < 500; k++) begin
      step(mk($urandom_range(3, 0) != 0, $urandom_range(1, 0),
              $urandom_range(3, 0) == 0, $urandom_range(15, 0),
              $urandom_range(255, 0)),
           mk($urandom_range(3, 0) != 0, $urandom_range(1, 0),
              $urandom_range(3, 0) == 0, $urandom_range(15, 0),
              $urandom_range(255, 0)));
      if (k == 250) rst_step(idle, idle);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end
endmodule
